// File: rtl/run_ctrl.sv
// run_ctrl: run/reset controller sitting between the board clock/reset and
// the multi-cycle RISC-V core.
//
// Purpose:
//   - Synchronises the external reset release and stretches it into a clean,
//     synchronously-deasserted core reset.
//   - Gates the core through a clock enable and counts enabled cycles.
//   - Ends a run on a core halt request or when the cycle budget runs out.
//   - Drives a heartbeat LED and one-hot status lines.
//
// Ports:
//   clk            in   system clock
//   resetn         in   asynchronous active-low reset
//   run_en         in   1 = core may advance, 0 = pause
//   halt_req       in   core halt request (ebreak/ecall), level-sampled
//   soft_reset_req in   synchronous restart request
//   core_resetn    out  active-low core reset, deasserted synchronously
//   core_clk_en    out  core clock enable (RUN and run_en)
//   cycle_count    out  enabled cycles since the last reset, saturating
//   halted         out  state is HALTED
//   timeout        out  state is TIMEOUT
//   led_heartbeat  out  status LED
//   state_onehot   out  {TIMEOUT, HALTED, RUN, RESET_HOLD}
//
// The registered state is also the debug view of the FSM: state_onehot is a
// direct decode of it.
module run_ctrl #(
  parameter int RESET_CYCLES   = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int MAX_CYCLES     = 8000,
  parameter int HEARTBEAT_LOG2 = 22
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 run_en,
  input  logic                 halt_req,
  input  logic                 soft_reset_req,
  output logic                 core_resetn,
  output logic                 core_clk_en,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic                 halted,
  output logic                 timeout,
  output logic                 led_heartbeat,
  output logic [3:0]           state_onehot
);

  typedef enum logic [1:0] {
    S_RESET_HOLD = 2'd0,
    S_RUN        = 2'd1,
    S_HALTED     = 2'd2,
    S_TIMEOUT    = 2'd3
  } state_t;

  // Hold counter only needs to reach RESET_CYCLES-1.
  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] MAX_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);
  localparam bit                   BUDGET_ON = (MAX_CYCLES != 0);

  state_t                    state_q, state_d;
  logic [1:0]                sync_q;
  logic [HOLD_W-1:0]         hold_q, hold_d;
  logic [CNT_WIDTH-1:0]      count_d, count_inc;
  logic [HEARTBEAT_LOG2-1:0] hb_q, hb_d;
  logic                      led_d;
  logic                      rst_synced;
  logic                      at_budget;

  // Two-flop synchroniser for the reset release. Only resetn clears it, so a
  // soft reset restarts the hold count without re-synchronising.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_synced = sync_q[1];
  assign count_inc  = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
  assign at_budget  = BUDGET_ON && (cycle_count == MAX_LAST);
  assign hb_d       = hb_q + 1'b1;

  // Next-state, hold counter and cycle counter.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    count_d = cycle_count;
    case (state_q)
      S_RESET_HOLD: begin
        count_d = '0;
        if (soft_reset_req) begin
          hold_d = '0;
        end else if (rst_synced) begin
          if (hold_q == HOLD_LAST) begin
            state_d = S_RUN;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (soft_reset_req) begin
          state_d = S_RESET_HOLD;
          hold_d  = '0;
          count_d = '0;
        end else begin
          // The final increment still lands on the edge that leaves RUN.
          if (run_en) begin
            count_d = count_inc;
          end
          if (halt_req) begin
            state_d = S_HALTED;
          end else if (run_en && at_budget) begin
            state_d = S_TIMEOUT;
          end
        end
      end
      S_HALTED, S_TIMEOUT: begin
        if (soft_reset_req) begin
          state_d = S_RESET_HOLD;
          hold_d  = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = S_RESET_HOLD;
        hold_d  = '0;
        count_d = '0;
      end
    endcase
  end

  // LED value for the state being entered, using the counter value that
  // becomes visible on the same edge.
  always_comb begin
    led_d = 1'b0;
    case (state_d)
      S_RESET_HOLD: led_d = 1'b0;
      S_RUN:        led_d = hb_d[HEARTBEAT_LOG2-1];
      S_HALTED:     led_d = 1'b1;
      S_TIMEOUT:    led_d = hb_d[HEARTBEAT_LOG2-3];
      default:      led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_RESET_HOLD;
      hold_q        <= '0;
      cycle_count   <= '0;
      hb_q          <= '0;
      core_resetn   <= 1'b0;
      led_heartbeat <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      cycle_count   <= count_d;
      hb_q          <= hb_d;
      // Dedicated flop so the core reset never sees a decode glitch.
      core_resetn   <= (state_d != S_RESET_HOLD);
      led_heartbeat <= led_d;
    end
  end

  assign core_clk_en = (state_q == S_RUN) && run_en;
  assign halted      = (state_q == S_HALTED);
  assign timeout     = (state_q == S_TIMEOUT);

  always_comb begin
    state_onehot = 4'b0000;
    case (state_q)
      S_RESET_HOLD: state_onehot = 4'b0001;
      S_RUN:        state_onehot = 4'b0010;
      S_HALTED:     state_onehot = 4'b0100;
      S_TIMEOUT:    state_onehot = 4'b1000;
      default:      state_onehot = 4'b0001;
    endcase
  end

endmodule

// File: tb/tb_run_ctrl.sv
`timescale 1ns/1ps
module tb_run_ctrl;

  localparam int RC   = 4;
  localparam int MAXC = 20;
  localparam int W    = 8;
  localparam int HB   = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic run_en = 1'b0;
  logic halt_req = 1'b0;
  logic soft_reset_req = 1'b0;

  logic         core_resetn;
  logic         core_clk_en;
  logic [W-1:0] cycle_count;
  logic         halted;
  logic         timeout;
  logic         led_heartbeat;
  logic [3:0]   state_onehot;

  always #5 clk = ~clk;

  run_ctrl #(
    .RESET_CYCLES(RC),
    .CNT_WIDTH(W),
    .MAX_CYCLES(MAXC),
    .HEARTBEAT_LOG2(HB)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .run_en(run_en),
    .halt_req(halt_req),
    .soft_reset_req(soft_reset_req),
    .core_resetn(core_resetn),
    .core_clk_en(core_clk_en),
    .cycle_count(cycle_count),
    .halted(halted),
    .timeout(timeout),
    .led_heartbeat(led_heartbeat),
    .state_onehot(state_onehot)
  );

  // Observed outputs packed for whole-output comparisons.
  logic [16:0] obs;
  assign obs = {core_resetn, core_clk_en, halted, timeout, led_heartbeat,
                state_onehot, cycle_count};

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: phase 0 hold, 1 run, 2 halted, 3 timeout.
  // m_edge counts rising edges since resetn was released; m_run_edge is the
  // edge number on which the run phase begins.
  int m_edge;
  int m_phase;
  int m_count;
  int m_run_edge;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [16:0] exp_vec(input logic re);
    int   hb;
    logic led;
    logic [3:0] oh;
    hb  = m_edge % (1 << HB);
    oh  = 4'b0001 << m_phase;
    led = 1'b0;
    case (m_phase)
      1: led = hb[HB-1];
      2: led = 1'b1;
      3: led = hb[HB-3];
      default: led = 1'b0;
    endcase
    return {m_phase != 0, (m_phase == 1) && re, m_phase == 2, m_phase == 3,
            led, oh, 8'(m_count)};
  endfunction

  task automatic model_init();
    m_edge = 0;
    m_phase = 0;
    m_count = 0;
    m_run_edge = 2 + RC;
  endtask

  task automatic model_step(input logic r, input logic h, input logic s);
    int old;
    m_edge++;
    case (m_phase)
      0: begin
        if (s) m_run_edge = max2(m_edge + RC, 2 + RC);
        else if (m_edge == m_run_edge) m_phase = 1;
      end
      1: begin
        if (s) begin
          m_phase = 0; m_count = 0; m_run_edge = m_edge + RC;
        end else begin
          old = m_count;
          if (r && m_count < (1 << W) - 1) m_count++;
          if (h) m_phase = 2;
          else if (r && old == MAXC - 1) m_phase = 3;
        end
      end
      default: begin
        if (s) begin
          m_phase = 0; m_count = 0; m_run_edge = m_edge + RC;
        end
      end
    endcase
  endtask

  // Driver: apply inputs away from the edge, advance one edge, step model,
  // leave the caller 1ns after the edge for sampling.
  task automatic cyc(input logic r, input logic h, input logic s);
    run_en = r; halt_req = h; soft_reset_req = s;
    @(posedge clk);
    model_step(r, h, s);
    #1;
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 60 && m_count != target; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs !== exp_vec(run_en))
        $display("FAIL run_to: got %h expected %h", obs, exp_vec(run_en));
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    run_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 17'b0_0_0_0_0_0001_00000000)
      $display("FAIL reset_values: got %h expected %h", obs, 17'b0_0_0_0_0_0001_00000000);
    else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    model_init();
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (core_resetn !== (i == 6))
        $display("FAIL release_core_resetn edge %0d: got %b expected %b", i, core_resetn, (i == 6));
      else n_pass++;
      n_checks++;
      if (state_onehot !== ((i == 6) ? 4'b0010 : 4'b0001))
        $display("FAIL release_onehot edge %0d: got %b expected %b", i, state_onehot,
                 ((i == 6) ? 4'b0010 : 4'b0001));
      else n_pass++;
    end
    n_checks++;
    if ({core_clk_en, cycle_count} !== {1'b1, 8'd0})
      $display("FAIL run_entry: got clk_en=%b count=%0d expected clk_en=1 count=0", core_clk_en, cycle_count);
    else n_pass++;
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 40 && m_phase != 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs !== exp_vec(run_en))
        $display("FAIL timeout_run: got %h expected %h", obs, exp_vec(run_en));
      else n_pass++;
    end
    n_checks++;
    if ({timeout, state_onehot, core_clk_en, cycle_count} !== {1'b1, 4'b1000, 1'b0, 8'd20})
      $display("FAIL timeout_entry: got to=%b oh=%b en=%b count=%0d expected to=1 oh=1000 en=0 count=20",
               timeout, state_onehot, core_clk_en, cycle_count);
    else n_pass++;
    // Blink pattern in TIMEOUT; halt_req must not move the state.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, (i == 3), 1'b0);
      n_checks++;
      if (obs !== exp_vec(run_en))
        $display("FAIL timeout_hold: got %h expected %h", obs, exp_vec(run_en));
      else n_pass++;
    end
  endtask

  task automatic test_soft_reset();
    cyc(1'b1, 1'b0, 1'b1);
    n_checks++;
    if ({core_resetn, cycle_count, state_onehot} !== {1'b0, 8'd0, 4'b0001})
      $display("FAIL soft_reset_entry: got resetn=%b count=%0d oh=%b expected resetn=0 count=0 oh=0001",
               core_resetn, cycle_count, state_onehot);
    else n_pass++;
    for (int k = 1; k <= RC; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (core_resetn !== (k == RC))
        $display("FAIL soft_reset_release edge %0d: got %b expected %b", k, core_resetn, (k == RC));
      else n_pass++;
    end
    n_checks++;
    if (obs !== exp_vec(run_en))
      $display("FAIL soft_reset_run: got %h expected %h", obs, exp_vec(run_en));
    else n_pass++;
  endtask

  task automatic test_halt();
    run_to(7);
    cyc(1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({halted, cycle_count, led_heartbeat, core_clk_en} !== {1'b1, 8'd8, 1'b1, 1'b0})
      $display("FAIL halt_entry: got h=%b count=%0d led=%b en=%b expected h=1 count=8 led=1 en=0",
               halted, cycle_count, led_heartbeat, core_clk_en);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (obs !== exp_vec(run_en))
        $display("FAIL halt_hold: got %h expected %h", obs, exp_vec(run_en));
      else n_pass++;
    end
  endtask

  task automatic test_pause();
    run_to(3);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({cycle_count, core_clk_en, state_onehot} !== {8'd3, 1'b0, 4'b0010})
        $display("FAIL pause: got count=%0d en=%b oh=%b expected count=3 en=0 oh=0010",
                 cycle_count, core_clk_en, state_onehot);
      else n_pass++;
    end
    cyc(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (cycle_count !== 8'd4)
      $display("FAIL pause_resume: got %0d expected 4", cycle_count);
    else n_pass++;
    // Random run_en pattern; may or may not reach the budget.
    for (int i = 0; i < 30; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      n_checks++;
      if (obs !== exp_vec(run_en))
        $display("FAIL pause_random: got %h expected %h", obs, exp_vec(run_en));
      else n_pass++;
    end
  endtask

  task automatic test_halt_at_timeout();
    test_soft_reset();
    run_to(MAXC - 1);
    cyc(1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({halted, timeout, cycle_count} !== {1'b1, 1'b0, 8'd20})
      $display("FAIL halt_at_timeout: got h=%b to=%b count=%0d expected h=1 to=0 count=20",
               halted, timeout, cycle_count);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    test_soft_reset();
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (obs !== 17'b0_0_0_0_0_0001_00000000)
      $display("FAIL async_reset: got %h expected %h", obs, 17'b0_0_0_0_0_0001_00000000);
    else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    model_init();
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs !== exp_vec(run_en))
        $display("FAIL async_resync edge %0d: got %h expected %h", i, obs, exp_vec(run_en));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic r, h, s;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 3) != 0);
      h = ($urandom_range(0, 31) == 0);
      s = ($urandom_range(0, 31) == 0);
      cyc(r, h, s);
      n_checks++;
      if (obs !== exp_vec(run_en))
        $display("FAIL random cycle %0d: got %h expected %h", i, obs, exp_vec(run_en));
      else n_pass++;
    end
  endtask

  initial begin
    model_init();
    test_reset();
    test_timeout();
    test_soft_reset();
    test_halt();
    test_soft_reset();
    test_pause();
    test_halt_at_timeout();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
